cpu_mem_responder: RTL and testbench

//  Memory-side responder for the 8-bit accumulator CPU bus (read/write/address/memoryIn/memoryOut).

---
 rtl/cpu_mem_responder.sv | 68 ++++++
 tb/tb_cpu_mem_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: RAM responder for the accumulator CPU with byte-serial boot loader.
// Optional macro MEM_WPROT_EN drops RUN writes below PROT_LIMIT and flags err.
module cpu_mem_responder #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int PROT_LIMIT = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] memoryIn,
  output logic [DATA_W-1:0] memoryOut,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              ld_restart,
  output logic              cpu_clr,
  output logic              err
);
  typedef enum logic {LOAD, RUN} state_t;
`ifdef MEM_WPROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif
  state_t            state;
  logic [ADDR_W-1:0] ld_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              prot;
  logic              last_slot;
  assign prot      = PROT_ON && (address < ADDR_W'(PROT_LIMIT));
  assign last_slot = ld_ptr == ADDR_W'(DEPTH - 1);
  assign memoryOut = (state == RUN && read) ? mem[address] : '0;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= LOAD;
      ld_ptr   <= '0;
      err      <= 1'b0;
      cpu_clr  <= 1'b1;
      ld_ready <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == LOAD) begin
      if (ld_valid && ld_ready) begin
        mem[ld_ptr] <= ld_data;
        // pointer saturates on the last word instead of wrapping
        ld_ptr <= last_slot ? ld_ptr : ld_ptr + 1'b1;
        if (ld_last || last_slot) begin
          state    <= RUN;
          cpu_clr  <= 1'b0;
          ld_ready <= 1'b0;
        end
      end
    end else begin
      if (write && !prot) mem[address] <= memoryIn;
      if (write && (read || prot)) err <= 1'b1;
      if (ld_restart) begin
        state    <= LOAD;
        ld_ptr   <= '0;
        cpu_clr  <= 1'b1;
        ld_ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed checks of loader, CPU access, restart, reset and protection.
module tb_cpu_mem_responder;
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] memoryIn = '0;
  logic [7:0] memoryOut;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_last = 1'b0;
  logic       ld_ready;
  logic       ld_restart = 1'b0;
  logic       cpu_clr;
  logic       err;
  int         errors = 0;
  int         checks = 0;
  localparam bit PROT =
`ifdef MEM_WPROT_EN
    1'b1;
`else
    1'b0;
`endif
  cpu_mem_responder dut (
    .clk(clk), .clr(clr), .read(read), .write(write), .address(address),
    .memoryIn(memoryIn), .memoryOut(memoryOut), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_restart(ld_restart), .cpu_clr(cpu_clr), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ld(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    read    = 1'b1;
    address = a;
    #1;
    chk(tag, memoryOut, exp);
    read = 1'b0;
    tick();
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    write    = 1'b1;
    address  = a;
    memoryIn = d;
    tick();
    write = 1'b0;
  endtask
  task automatic restart;
    ld_restart = 1'b1;
    tick();
    ld_restart = 1'b0;
  endtask
  initial begin
    tick();
    read = 1'b1;
    #1;
    chk("rst_cpu_clr", 8'(cpu_clr), 8'h01);
    chk("rst_ld_ready", 8'(ld_ready), 8'h01);
    chk("rst_err", 8'(err), 8'h00);
    chk("rst_memout", memoryOut, 8'h00);
    read = 1'b0;
    clr  = 1'b1;
    tick();
    ld(8'h41, 1'b0);
    ld(8'h12, 1'b0);
    chk("t1_clr_held", 8'(cpu_clr), 8'h01);
    ld(8'h50, 1'b1);
    chk("t1_clr_fall", 8'(cpu_clr), 8'h00);
    chk("t1_ready_low", 8'(ld_ready), 8'h00);
    rd("t1_m0", 4'd0, 8'h41);
    rd("t1_m1", 4'd1, 8'h12);
    rd("t3_m2", 4'd2, 8'h50);
    chk("t3_noread", memoryOut, 8'h00);
    wr(4'd9, 8'hA5);
    rd("t3_m9", 4'd9, 8'hA5);
    chk("t3_err0", 8'(err), 8'h00);
    read = 1'b1; write = 1'b1; address = 4'd9; memoryIn = 8'h3C;
    #1;
    chk("t4_preword", memoryOut, 8'hA5);
    tick();
    read = 1'b0; write = 1'b0;
    chk("t4_err", 8'(err), 8'h01);
    rd("t4_m9", 4'd9, 8'h3C);
    tick();
    chk("t4_err_sticky", 8'(err), 8'h01);
    restart();
    chk("t5_cpu_clr", 8'(cpu_clr), 8'h01);
    chk("t5_ready", 8'(ld_ready), 8'h01);
    rd("t5_load_rd0", 4'd9, 8'h00);
    ld(8'h11, 1'b1);
    rd("t5_ptr0", 4'd0, 8'h11);
    rd("t5_keep1", 4'd1, 8'h12);
    rd("t5_keep9", 4'd9, 8'h3C);
    restart();
    for (int i = 0; i < 16; i++) begin
      ld(8'h80 + 8'(i), 1'b0);
      if (i == 14) chk("t2_ready15", 8'(ld_ready), 8'h01);
    end
    chk("t2_ready16", 8'(ld_ready), 8'h00);
    chk("t2_run", 8'(cpu_clr), 8'h00);
    ld(8'hEE, 1'b0);
    rd("t2_m0", 4'd0, 8'h80);
    rd("t2_m15", 4'd15, 8'h8F);
    rd("t2_m9", 4'd9, 8'h89);
    restart();
    ld(8'h99, 1'b0);
    clr = 1'b0;
    #1;
    chk("t5_arst_err", 8'(err), 8'h00);
    chk("t5_arst_clr", 8'(cpu_clr), 8'h01);
    tick();
    clr = 1'b1;
    tick();
    ld(8'h77, 1'b1);
    rd("t5_arst_m0", 4'd0, 8'h77);
    rd("t5_arst_m1", 4'd1, 8'h00);
    rd("t5_arst_m5", 4'd5, 8'h00);
    wr(4'd3, 8'hFF);
    rd("t6_m3", 4'd3, PROT ? 8'h00 : 8'hFF);
    chk("t6_err", 8'(err), PROT ? 8'h01 : 8'h00);
    wr(4'd8, 8'h5A);
    rd("t6_m8", 4'd8, 8'h5A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
